// File: rtl/bot_app_if.sv
// Application-side endpoint of the BOTSIM system-register interface: snapshots
// BOTSIM registers on each update toggle, interrupts the PicoBlaze, drives MotCtl/BotConfig.
module bot_app_if #(
  parameter logic [7:0]  BASE_ADDR   = 8'h00,
  parameter logic [23:0] WDOG_CYCLES = 24'd2_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] port_id,
  input  logic       write_strobe,
  input  logic       read_strobe,
  input  logic [7:0] out_port,
  output logic [7:0] in_port,
  output logic       interrupt,
  input  logic       interrupt_ack,
  input  logic       upd_sysregs,
  input  logic [7:0] LocX,
  input  logic [7:0] LocY,
  input  logic [7:0] BotInfo,
  input  logic [7:0] Sensors,
  input  logic [7:0] LMDist,
  input  logic [7:0] RMDist,
  output logic [7:0] MotCtl,
  output logic [7:0] BotConfig
);

  typedef enum logic {IDLE, PEND} state_t;

  localparam logic [23:0] WDOG_MAX = WDOG_CYCLES - 24'd1;

  state_t      state;
  logic        upd_q;
  logic        upd_evt;
  logic [7:0]  snap_x, snap_y, snap_info, snap_sens, snap_ld, snap_rd;
  logic [7:0]  ovr_cnt;
  logic [7:0]  ovr_base;
  logic [23:0] wdog_cnt;
  logic        stale;
  logic        sel;
  logic [3:0]  idx;
  logic        wr;
  logic        clr_ovr;
  logic        ovr_evt;
  logic [7:0]  rd_data;
  logic        unused_rd;

  // Read strobe has no side effects; reads are purely address-driven.
  assign unused_rd = read_strobe;

  assign upd_evt   = upd_sysregs ^ upd_q;
  assign sel       = (port_id[7:4] == BASE_ADDR[7:4]);
  assign idx       = port_id[3:0];
  assign wr        = write_strobe & sel;
  assign clr_ovr   = wr && (idx == 4'hA);
  assign ovr_evt   = (state == PEND) && upd_evt && !interrupt_ack;
  assign interrupt = (state == PEND);
  // Clear is applied first so a coincident overrun leaves the count at 1.
  assign ovr_base  = clr_ovr ? '0 : ovr_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      ovr_cnt <= '0;
    end else begin
      case (state)
        IDLE: if (upd_evt) state <= PEND;
        PEND: if (interrupt_ack && !upd_evt) state <= IDLE;
        default: state <= IDLE;
      endcase
      if (ovr_evt && ovr_base != 8'hFF) ovr_cnt <= ovr_base + 8'd1;
      else                              ovr_cnt <= ovr_base;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      upd_q     <= 1'b0;
      snap_x    <= '0;
      snap_y    <= '0;
      snap_info <= '0;
      snap_sens <= '0;
      snap_ld   <= '0;
      snap_rd   <= '0;
    end else begin
      upd_q <= upd_sysregs;
      if (upd_evt) begin
        snap_x    <= LocX;
        snap_y    <= LocY;
        snap_info <= BotInfo;
        snap_sens <= Sensors;
        snap_ld   <= LMDist;
        snap_rd   <= RMDist;
      end
    end
  end

  // stale tracks the next counter value so it rises on the edge the counter saturates.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wdog_cnt <= '0;
      stale    <= 1'b0;
    end else if (upd_evt) begin
      wdog_cnt <= '0;
      stale    <= 1'b0;
    end else if (wdog_cnt != WDOG_MAX) begin
      wdog_cnt <= wdog_cnt + 24'd1;
      stale    <= ((wdog_cnt + 24'd1) == WDOG_MAX);
    end
  end

  always_comb begin
    rd_data = '0;
    if (sel) begin
      case (idx)
        4'h0:    rd_data = snap_x;
        4'h1:    rd_data = snap_y;
        4'h2:    rd_data = snap_info;
        4'h3:    rd_data = snap_sens;
        4'h4:    rd_data = snap_ld;
        4'h5:    rd_data = snap_rd;
        4'h6:    rd_data = {stale, interrupt, 6'b0};
        4'h7:    rd_data = ovr_cnt;
        4'h8:    rd_data = MotCtl;
        4'h9:    rd_data = BotConfig;
        default: rd_data = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in_port   <= '0;
      MotCtl    <= '0;
      BotConfig <= '0;
    end else begin
      in_port <= rd_data;
      if (wr && idx == 4'h8) MotCtl    <= out_port;
      if (wr && idx == 4'h9) BotConfig <= out_port;
    end
  end

endmodule

// File: tb/tb_bot_app_if.sv
// Randomized bench for bot_app_if: a transaction-level model predicts every output
// each cycle, and a few directed sequences pin absolute values.
module tb_bot_app_if;

  localparam int WDOG = 16;

  logic       clk, reset;
  logic [7:0] port_id, out_port, in_port;
  logic       write_strobe, read_strobe, interrupt, interrupt_ack, upd_sysregs;
  logic [7:0] LocX, LocY, BotInfo, Sensors, LMDist, RMDist, MotCtl, BotConfig;

  bot_app_if #(.BASE_ADDR(8'h00), .WDOG_CYCLES(24'd16)) dut (
    .clk(clk), .reset(reset), .port_id(port_id), .write_strobe(write_strobe),
    .read_strobe(read_strobe), .out_port(out_port), .in_port(in_port),
    .interrupt(interrupt), .interrupt_ack(interrupt_ack), .upd_sysregs(upd_sysregs),
    .LocX(LocX), .LocY(LocY), .BotInfo(BotInfo), .Sensors(Sensors),
    .LMDist(LMDist), .RMDist(RMDist), .MotCtl(MotCtl), .BotConfig(BotConfig)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int vectors = 0;
  int miscompares = 0;

  // Model state: pending flag, overrun count, cycles since last update, etc.
  logic       m_prev;
  logic [7:0] m_snap [6];
  bit         m_pend;
  int         m_ovr;
  int         m_wd;
  logic [7:0] m_mot, m_cfg, m_in;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_prev = 1'b0;
    for (int i = 0; i < 6; i++) m_snap[i] = 8'h00;
    m_pend = 0; m_ovr = 0; m_wd = 0;
    m_mot = 8'h00; m_cfg = 8'h00; m_in = 8'h00;
  endtask

  task automatic model_step();
    bit evt, sel, stale_now;
    int idx;
    evt = (upd_sysregs != m_prev);
    sel = (port_id[7:4] == 4'h0);
    idx = int'(port_id[3:0]);
    stale_now = (m_wd >= WDOG - 1);
    if (!sel)          m_in = 8'h00;
    else if (idx < 6)  m_in = m_snap[idx];
    else if (idx == 6) m_in = {stale_now, m_pend, 6'b0};
    else if (idx == 7) m_in = 8'(m_ovr);
    else if (idx == 8) m_in = m_mot;
    else if (idx == 9) m_in = m_cfg;
    else               m_in = 8'h00;
    if (write_strobe && sel) begin
      if (idx == 8)  m_mot = out_port;
      if (idx == 9)  m_cfg = out_port;
      if (idx == 10) m_ovr = 0;
    end
    if (m_pend && evt && !interrupt_ack) m_ovr = (m_ovr < 255) ? m_ovr + 1 : 255;
    m_pend = evt || (m_pend && !interrupt_ack);
    if (evt) begin
      m_snap[0] = LocX; m_snap[1] = LocY; m_snap[2] = BotInfo;
      m_snap[3] = Sensors; m_snap[4] = LMDist; m_snap[5] = RMDist;
    end
    m_wd = evt ? 0 : (m_wd < 1000000 ? m_wd + 1 : m_wd);
    m_prev = upd_sysregs;
  endtask

  // Single compare process: every clock edge and every reset assertion.
  initial begin
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) model_reset();
      else        model_step();
      #1;
      vectors++;
      chk("in_port",   in_port,   m_in);
      chk("interrupt", {7'b0, interrupt}, {7'b0, m_pend});
      chk("MotCtl",    MotCtl,    m_mot);
      chk("BotConfig", BotConfig, m_cfg);
    end
  end

  task automatic lit(input string name, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    chk(name, act, exp);
  endtask

  task automatic nclk(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    reset = 1'b0; port_id = 8'h06; write_strobe = 0; read_strobe = 0; out_port = 0;
    interrupt_ack = 0; upd_sysregs = 0;
    LocX = 0; LocY = 0; BotInfo = 0; Sensors = 0; LMDist = 0; RMDist = 0;
    nclk(3);
    lit("rst_in_port", in_port, 8'h00);
    lit("rst_motctl", MotCtl, 8'h00);
    reset = 1'b1;

    // Watchdog: stale visible in status after the 15th edge has been read back
    nclk(15);
    lit("wdog_pre", in_port, 8'h00);
    nclk(1);
    lit("wdog_set", in_port, 8'h80);
    nclk(5);
    lit("wdog_sticky", in_port, 8'h80);

    // First update
    LocX = 8'h12; LocY = 8'h34; upd_sysregs = 1; port_id = 8'h00;
    nclk(1);
    lit("irq_rise", {7'b0, interrupt}, 8'h01);
    lit("read_pre_update", in_port, 8'h00);
    nclk(1);
    lit("locx", in_port, 8'h12);
    port_id = 8'h01;
    nclk(1);
    lit("locy", in_port, 8'h34);
    port_id = 8'h06;
    nclk(1);
    lit("status_irq", in_port, 8'h40);

    // Ack, then ack coincident with a new update
    interrupt_ack = 1;
    nclk(1);
    lit("irq_ack", {7'b0, interrupt}, 8'h00);
    interrupt_ack = 0;
    nclk(1);
    lit("status_idle", in_port, 8'h00);
    upd_sysregs = ~upd_sysregs;
    nclk(1);
    interrupt_ack = 1; upd_sysregs = ~upd_sysregs;
    nclk(1);
    lit("ack_and_upd", {7'b0, interrupt}, 8'h01);
    interrupt_ack = 0; port_id = 8'h07;
    nclk(1);
    lit("no_overrun", in_port, 8'h00);

    // Overruns and latest-wins snapshot
    interrupt_ack = 1;
    nclk(1);
    interrupt_ack = 0;
    Sensors = 8'hA1; upd_sysregs = ~upd_sysregs; nclk(1);
    Sensors = 8'hA2; upd_sysregs = ~upd_sysregs; nclk(1);
    Sensors = 8'hA3; upd_sysregs = ~upd_sysregs; nclk(1);
    nclk(1);
    lit("overrun2", in_port, 8'h02);
    port_id = 8'h03;
    nclk(1);
    lit("sens_latest", in_port, 8'hA3);
    port_id = 8'h0A; out_port = 8'h55; write_strobe = 1;
    nclk(1);
    write_strobe = 0; port_id = 8'h07;
    nclk(1);
    lit("overrun_clr", in_port, 8'h00);
    for (int i = 0; i < 260; i++) begin
      upd_sysregs = ~upd_sysregs;
      nclk(1);
    end
    nclk(2);
    lit("overrun_sat", in_port, 8'hFF);

    // Register writes and base mismatch
    port_id = 8'h08; out_port = 8'hB5; write_strobe = 1;
    nclk(1);
    port_id = 8'h09; out_port = 8'h03;
    nclk(1);
    write_strobe = 0; port_id = 8'h08;
    lit("motctl_wr", MotCtl, 8'hB5);
    nclk(1);
    lit("botcfg_wr", BotConfig, 8'h03);
    lit("motctl_rd", in_port, 8'hB5);
    port_id = 8'h18; out_port = 8'hFF; write_strobe = 1;
    nclk(1);
    write_strobe = 0;
    lit("mismatch_wr", MotCtl, 8'hB5);
    lit("mismatch_rd", in_port, 8'h00);

    // Asynchronous reset while pending
    upd_sysregs = ~upd_sysregs;
    nclk(2);
    #2 reset = 1'b0;
    #1;
    lit("arst_irq", {7'b0, interrupt}, 8'h00);
    lit("arst_motctl", MotCtl, 8'h00);
    upd_sysregs = 0; port_id = 8'h07;
    nclk(2);
    reset = 1'b1;
    nclk(1);
    lit("arst_ovr", in_port, 8'h00);
    port_id = 8'h03;
    nclk(1);
    lit("arst_snap", in_port, 8'h00);

    // Randomized traffic with periodic quiet windows for the watchdog
    for (int i = 0; i < 3000; i++) begin
      if ((i % 500) >= 40 && $urandom_range(0, 9) < 3) upd_sysregs = ~upd_sysregs;
      interrupt_ack = ($urandom_range(0, 4) == 0);
      write_strobe  = ($urandom_range(0, 3) == 0);
      read_strobe   = $urandom_range(0, 1) == 1;
      port_id = 8'($urandom_range(0, 15));
      if ($urandom_range(0, 9) == 0) port_id[7:4] = 4'($urandom_range(1, 15));
      out_port = 8'($urandom);
      LocX = 8'($urandom); LocY = 8'($urandom); BotInfo = 8'($urandom);
      Sensors = 8'($urandom); LMDist = 8'($urandom); RMDist = 8'($urandom);
      nclk(1);
    end
    write_strobe = 0; interrupt_ack = 0;
    nclk(2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
